// File: rtl/pe_os_mac_if.sv
// Operand, control and result-chain signals of one output-stationary PE.
// master = neighbour/controller side, slave = the PE itself.
interface pe_os_mac_if #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int KW = 9
);
    // v_in qualifies a_in/b_in on every clock edge where en=1. There is no
    // backpressure: en=0 is the only way to stall, and it freezes the whole PE.
    logic          en;
    logic          start;
    logic [KW-1:0] k_len;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          v_in;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          v_out;
    logic          drain;
    logic [AW-1:0] c_in;
    logic [AW-1:0] c_out;
    logic          done;
    logic          ovf;
    logic [1:0]    state;

    modport master (
        output en, start, k_len, a_in, b_in, v_in, drain, c_in,
        input  a_out, b_out, v_out, c_out, done, ovf, state
    );

    modport slave (
        input  en, start, k_len, a_in, b_in, v_in, drain, c_in,
        output a_out, b_out, v_out, c_out, done, ovf, state
    );
endinterface

// File: rtl/pe_os_mac.sv
// Output-stationary MAC PE: operand forwarding, one-stage multiply, K-length accumulate, serial result drain.
// Define PE_OS_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pe_os_mac #(
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int K_MAX  = 256,
    parameter int SIGNED = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pe_os_mac_if.slave   bus
);
    localparam int KW = $clog2(K_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   a_q, b_q;
    logic            v_q;
    logic [2*DW-1:0] prod_q, prod_d;
    logic            pv_q, pv_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   c_q, c_d;
    logic            ovf_q, ovf_d;

    logic [2*DW-1:0] a_ext, b_ext;
    logic [AW-1:0]   p_ext;
    logic [AW:0]     sum;
    logic            ovf_add;
    logic [AW-1:0]   acc_add;
    logic [KW-1:0]   cnt_inc;
    logic            do_start;

    // Extending to 2*DW before multiplying makes the low 2*DW product bits correct for either signedness.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = (2*DW)'($signed(bus.a_in));
            b_ext = (2*DW)'($signed(bus.b_in));
            p_ext = AW'($signed(prod_q));
        end else begin
            a_ext = (2*DW)'(bus.a_in);
            b_ext = (2*DW)'(bus.b_in);
            p_ext = AW'(prod_q);
        end
        prod_d = a_ext * b_ext;
        pv_d   = bus.v_in & (state_q == S_ACC) & ~bus.start;
    end

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, p_ext};
        if (SIGNED != 0)
            ovf_add = (acc_q[AW-1] == p_ext[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
        else
            ovf_add = sum[AW];
`ifdef PE_OS_MAC_SATURATE_EN
        if (ovf_add) begin
            if (SIGNED != 0)
                acc_add = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            else
                acc_add = {AW{1'b1}};
        end else begin
            acc_add = sum[AW-1:0];
        end
`else
        acc_add = sum[AW-1:0];
`endif
        cnt_inc = cnt_q + KW'(1);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        do_start = bus.start && (state_q != S_DRAIN);
        if (do_start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            k_d   = bus.k_len;
            if (bus.k_len == '0) begin
                state_d = S_DONE;
                c_d     = '0;
            end else begin
                state_d = S_ACC;
            end
        end else begin
            case (state_q)
                S_ACC: begin
                    if (pv_q) begin
                        acc_d = acc_add;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | ovf_add;
                        if (cnt_inc == k_q) begin
                            state_d = S_DONE;
                            c_d     = acc_add;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.drain) begin
                        state_d = S_DRAIN;
                        c_d     = bus.c_in;
                    end
                end
                S_DRAIN: begin
                    if (bus.drain) c_d = bus.c_in;
                    else           state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            v_q     <= 1'b0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.en) begin
            state_q <= state_d;
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            v_q     <= bus.v_in;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
    assign bus.v_out = v_q;
    assign bus.c_out = c_q;
    assign bus.done  = (state_q == S_DONE);
    assign bus.ovf   = ovf_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_pe_os_mac.sv
// Directed bench for pe_os_mac: forwarding, dot products, stalls, overflow, 3-PE drain chain, async reset.
module tb_pe_os_mac;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef PE_OS_MAC_SATURATE_EN
    localparam logic [31:0] OVF_RESULT = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_RESULT = 32'h8000_0000;
`endif

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pe_os_mac_if #(.DW(16), .AW(32), .KW(9)) bus ();
    pe_os_mac_if #(.DW(16), .AW(32), .KW(9)) cf0 ();
    pe_os_mac_if #(.DW(16), .AW(32), .KW(9)) cf1 ();
    pe_os_mac_if #(.DW(16), .AW(32), .KW(9)) cf2 ();

    pe_os_mac u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    pe_os_mac u_pe0 (.clk_i(clk), .rst_ni(rst_n), .bus(cf0));
    pe_os_mac u_pe1 (.clk_i(clk), .rst_ni(rst_n), .bus(cf1));
    pe_os_mac u_pe2 (.clk_i(clk), .rst_ni(rst_n), .bus(cf2));

    // Top of the chain sees a marker value; each lower PE takes its upper neighbour's result.
    assign cf0.c_in = 32'h0000_DEAD;
    assign cf1.c_in = cf0.c_out;
    assign cf2.c_in = cf1.c_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chain_drive(input logic en, input logic start, input logic v,
                               input logic drain, input logic [15:0] a0,
                               input logic [15:0] a1, input logic [15:0] a2);
        cf0.en = en; cf1.en = en; cf2.en = en;
        cf0.start = start; cf1.start = start; cf2.start = start;
        cf0.k_len = 9'd1; cf1.k_len = 9'd1; cf2.k_len = 9'd1;
        cf0.v_in = v; cf1.v_in = v; cf2.v_in = v;
        cf0.drain = drain; cf1.drain = drain; cf2.drain = drain;
        cf0.a_in = a0; cf1.a_in = a1; cf2.a_in = a2;
        cf0.b_in = 16'd1; cf1.b_in = 16'd1; cf2.b_in = 16'd1;
    endtask

    initial begin
        bus.en = 1'b0; bus.start = 1'b0; bus.k_len = '0; bus.a_in = '0;
        bus.b_in = '0; bus.v_in = 1'b0; bus.drain = 1'b0; bus.c_in = '0;
        chain_drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        rst_n = 1'b0;
        #12;
        check("rst_c_out", bus.c_out, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_state", bus.state, S_IDLE);
        tick();
        rst_n = 1'b1;

        // Forwarding with no START: nothing accumulates
        bus.en = 1'b1; bus.v_in = 1'b1; bus.a_in = 16'd3; bus.b_in = 16'd4;
        tick();
        check("fwd_a", bus.a_out, 3);
        check("fwd_b", bus.b_out, 4);
        check("fwd_v", bus.v_out, 1);
        repeat (4) tick();
        check("idle_done", bus.done, 0);
        check("idle_c_out", bus.c_out, 0);
        check("idle_state", bus.state, S_IDLE);

        // K=4 signed dot product: 6 - 5 + 7 + 0 = 8
        bus.v_in = 1'b0; bus.start = 1'b1; bus.k_len = 9'd4;
        tick();
        check("k4_state_acc", bus.state, S_ACC);
        bus.start = 1'b0; bus.v_in = 1'b1;
        bus.a_in = 16'd2;    bus.b_in = 16'd3; tick();
        bus.a_in = 16'hFFFF; bus.b_in = 16'd5; tick();
        bus.a_in = 16'd7;    bus.b_in = 16'd1; tick();
        bus.a_in = 16'd0;    bus.b_in = 16'd9; tick();
        check("k4_not_done_yet", bus.done, 0);
        bus.a_in = 16'd1; bus.b_in = 16'd1;
        tick();
        check("k4_done", bus.done, 1);
        check("k4_c_out", bus.c_out, 8);
        check("k4_ovf", bus.ovf, 0);
        tick();
        check("k4_extra_ignored", bus.c_out, 8);
        check("k4_state_done", bus.state, S_DONE);

        // K=3 with valid gaps and a 2-cycle stall: 10 + 20 + 30 = 60
        bus.v_in = 1'b0; bus.start = 1'b1; bus.k_len = 9'd3;
        tick();
        bus.start = 1'b0;
        bus.v_in = 1'b1; bus.a_in = 16'd2; bus.b_in = 16'd5; tick();
        bus.v_in = 1'b0; tick();
        bus.v_in = 1'b1; bus.a_in = 16'd4; bus.b_in = 16'd5; tick();
        bus.en = 1'b0; bus.a_in = 16'd9; bus.b_in = 16'd9;
        tick(); tick();
        check("stall_a_held", bus.a_out, 4);
        check("stall_state", bus.state, S_ACC);
        bus.en = 1'b1; bus.a_in = 16'd5; bus.b_in = 16'd6; tick();
        bus.v_in = 1'b0; tick();
        check("k3_done", bus.done, 1);
        check("k3_c_out", bus.c_out, 60);

        // Signed overflow: 0x40000000 + 0x40000000
        bus.start = 1'b1; bus.k_len = 9'd2;
        tick();
        bus.start = 1'b0; bus.v_in = 1'b1; bus.a_in = 16'h8000; bus.b_in = 16'h8000;
        tick(); tick();
        bus.v_in = 1'b0;
        tick();
        check("ovf_done", bus.done, 1);
        check("ovf_flag", bus.ovf, 1);
        check("ovf_c_out", bus.c_out, OVF_RESULT);

        // Drain chain of three PEs holding 5, 6, 7 (top to bottom)
        chain_drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0); tick();
        chain_drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 16'd6, 16'd7); tick();
        chain_drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0); tick();
        check("chain_bot_done", cf2.done, 1);
        check("chain_bot_0", cf2.c_out, 7);
        chain_drive(1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        tick();
        check("chain_bot_1", cf2.c_out, 6);
        check("chain_state_drain", cf2.state, S_DRAIN);
        tick();
        check("chain_bot_2", cf2.c_out, 5);
        tick();
        check("chain_bot_3", cf2.c_out, 32'h0000_DEAD);
        chain_drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        check("chain_top_idle", cf0.state, S_IDLE);
        check("chain_mid_idle", cf1.state, S_IDLE);
        check("chain_bot_idle", cf2.state, S_IDLE);
        check("chain_bot_held", cf2.c_out, 32'h0000_DEAD);

        // Async reset in the middle of an accumulation
        bus.start = 1'b1; bus.k_len = 9'd4;
        tick();
        bus.start = 1'b0; bus.v_in = 1'b1; bus.a_in = 16'd1; bus.b_in = 16'd1;
        tick(); tick(); tick();
        check("pre_rst_state", bus.state, S_ACC);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_c_out", bus.c_out, 0);
        check("mid_rst_ovf", bus.ovf, 0);
        check("mid_rst_a_out", bus.a_out, 0);
        check("mid_rst_v_out", bus.v_out, 0);
        check("mid_rst_state", bus.state, S_IDLE);
        tick();
        rst_n = 1'b1;
        bus.v_in = 1'b0; bus.start = 1'b1; bus.k_len = 9'd0;
        tick();
        bus.start = 1'b0;
        check("k0_done", bus.done, 1);
        check("k0_c_out", bus.c_out, 0);
        check("k0_state", bus.state, S_DONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
